// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM, PC redirect and the MEM/WB register.
// Optional data-memory timeout/abort logic is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_branch,
  input  logic        mem_jump,
  input  logic        mem_jumptoreg,
  input  logic        mem_zero,
  input  logic        mem_link,
  input  logic        mem_memwrite,
  input  logic        mem_memtoreg,
  input  logic        mem_regwriteen,
  input  logic [31:0] mem_aluout,
  input  logic [31:0] mem_memwritedata,
  input  logic [31:0] mem_pcplus4,
  input  logic [31:0] mem_pcnext,
  input  logic [4:0]  mem_writereg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_regwriteen,
  output logic [4:0]  wb_writereg,
  output logic [31:0] wb_result,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("mem_stage: TIMEOUT_CYCLES out of range 1-255");
  end

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic        req_next, we_next;
  logic [31:0] addr_next, wdata_next;
  logic        wb_valid_next, wb_regwriteen_next;
  logic [4:0]  wb_writereg_next;
  logic [31:0] wb_result_next;
  logic        err_next;
  logic        memop;
  logic [31:0] result_sel;

  assign memop = mem_valid & (mem_memtoreg | mem_memwrite);

  // A store with memtoreg also set still returns the address, never read data.
  assign result_sel = mem_link ? mem_pcplus4 :
                      (mem_memtoreg & ~mem_memwrite) ? dmem_rdata : mem_aluout;

  assign stall = ((state_reg == S_IDLE) & memop) | ((state_reg == S_WAIT) & ~dmem_ready);

  assign redirect = mem_valid & (state_reg == S_IDLE) &
                    ((mem_branch & mem_zero) | mem_jump | mem_jumptoreg);
  assign redirect_pc = mem_pcnext;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_reg, cnt_next;
`endif

  always_comb begin
    state_next         = state_reg;
    req_next           = dmem_req;
    we_next            = dmem_we;
    addr_next          = dmem_addr;
    wdata_next         = dmem_wdata;
    wb_valid_next      = 1'b0;
    wb_regwriteen_next = wb_regwriteen;
    wb_writereg_next   = wb_writereg;
    wb_result_next     = wb_result;
    err_next           = err;
`ifdef MEM_TIMEOUT_EN
    cnt_next           = cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (memop) begin
          req_next   = 1'b1;
          we_next    = mem_memwrite;
          addr_next  = mem_aluout;
          wdata_next = mem_memwritedata;
          state_next = S_WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_next   = 8'd0;
`endif
        end else if (mem_valid) begin
          wb_valid_next      = 1'b1;
          wb_regwriteen_next = mem_regwriteen;
          wb_writereg_next   = mem_writereg;
          wb_result_next     = result_sel;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          req_next           = 1'b0;
          state_next         = S_IDLE;
          wb_valid_next      = 1'b1;
          wb_regwriteen_next = mem_regwriteen;
          wb_writereg_next   = mem_writereg;
          wb_result_next     = result_sel;
        end
`ifdef MEM_TIMEOUT_EN
        // Abort retires the instruction without a register write.
        else if (cnt_reg == TIMEOUT_LIMIT) begin
          req_next           = 1'b0;
          state_next         = S_IDLE;
          err_next           = 1'b1;
          wb_valid_next      = 1'b1;
          wb_regwriteen_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      wb_valid      <= 1'b0;
      wb_regwriteen <= 1'b0;
      wb_writereg   <= 5'd0;
      wb_result     <= 32'd0;
      err           <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dmem_req      <= req_next;
      dmem_we       <= we_next;
      dmem_addr     <= addr_next;
      dmem_wdata    <= wdata_next;
      wb_valid      <= wb_valid_next;
      wb_regwriteen <= wb_regwriteen_next;
      wb_writereg   <= wb_writereg_next;
      wb_result     <= wb_result_next;
      err           <= err_next;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) cnt_reg <= 8'd0;
    else        cnt_reg <= cnt_next;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then randomized instructions
// checked against transaction-level expectations (result rule, stall count, latency).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_branch, mem_jump, mem_jumptoreg, mem_zero, mem_link;
  logic        mem_memwrite, mem_memtoreg, mem_regwriteen;
  logic [31:0] mem_aluout, mem_memwritedata, mem_pcplus4, mem_pcnext;
  logic [4:0]  mem_writereg;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        redirect, stall, wb_valid, wb_regwriteen, err;
  logic [31:0] redirect_pc, wb_result;
  logic [4:0]  wb_writereg;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_jump(mem_jump),
    .mem_jumptoreg(mem_jumptoreg), .mem_zero(mem_zero), .mem_link(mem_link),
    .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg), .mem_regwriteen(mem_regwriteen),
    .mem_aluout(mem_aluout), .mem_memwritedata(mem_memwritedata),
    .mem_pcplus4(mem_pcplus4), .mem_pcnext(mem_pcnext), .mem_writereg(mem_writereg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .wb_valid(wb_valid), .wb_regwriteen(wb_regwriteen), .wb_writereg(wb_writereg),
    .wb_result(wb_result), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {mem_valid, mem_branch, mem_jump, mem_jumptoreg, mem_zero, mem_link} = '0;
    {mem_memwrite, mem_memtoreg, mem_regwriteen} = '0;
    mem_aluout = '0; mem_memwritedata = '0; mem_pcplus4 = '0; mem_pcnext = '0;
    mem_writereg = '0; dmem_ready = 1'b0; dmem_rdata = '0;
  endtask

  // One instruction through MEM; expectations come from the stage's retirement rules.
  task automatic run_op(input bit ld, input bit st, input bit lnk, input bit br, input bit zr,
                        input bit jp, input bit jr, input bit rwe, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input logic [31:0] pcn, input logic [31:0] rdata, input int delay);
    bit memop, exp_redir;
    logic [31:0] exp_res;
    int stalls;
    memop = ld | st;
    exp_redir = (br & zr) | jp | jr;
    exp_res = lnk ? pc4 : ((ld && !st) ? rdata : alu);
    stalls = 0;
    mem_valid = 1'b1; mem_memtoreg = ld; mem_memwrite = st; mem_link = lnk;
    mem_branch = br; mem_zero = zr; mem_jump = jp; mem_jumptoreg = jr;
    mem_regwriteen = rwe; mem_writereg = wr; mem_aluout = alu; mem_memwritedata = wd;
    mem_pcplus4 = pc4; mem_pcnext = pcn; dmem_ready = 1'b0; dmem_rdata = $urandom;
    #1;
    chk("redirect", 32'(redirect), 32'(exp_redir));
    chk("redirect_pc", redirect_pc, pcn);
    chk("stall_entry", 32'(stall), 32'(memop));
    if (memop) begin
      stalls++;
      tick();
      chk("req_on", 32'(dmem_req), 1);
      chk("we", 32'(dmem_we), 32'(st));
      chk("addr", dmem_addr, alu);
      chk("wdata", dmem_wdata, wd);
      chk("wb_valid_early", 32'(wb_valid), 0);
      for (int i = 0; i < delay; i++) begin
        chk("stall_wait", 32'(stall), 1);
        chk("redirect_wait", 32'(redirect), 0);
        stalls++;
        tick();
        chk("req_held", 32'(dmem_req), 1);
        chk("addr_held", dmem_addr, alu);
        chk("wb_valid_wait", 32'(wb_valid), 0);
      end
      dmem_ready = 1'b1;
      dmem_rdata = rdata;
      #1;
      chk("stall_ready", 32'(stall), 0);
      tick();
      dmem_ready = 1'b0;
      chk("req_off", 32'(dmem_req), 0);
      chk("stall_cycles", 32'(stalls), 32'(delay + 1));
    end else begin
      tick();
    end
    chk("wb_valid", 32'(wb_valid), 1);
    chk("wb_result", wb_result, exp_res);
    chk("wb_writereg", 32'(wb_writereg), 32'(wr));
    chk("wb_regwriteen", 32'(wb_regwriteen), 32'(rwe));
    last_res = exp_res;
  endtask

  task automatic idle_cycle();
    clear_inputs();
    #1;
    chk("idle_stall", 32'(stall), 0);
    tick();
    chk("idle_wb_valid", 32'(wb_valid), 0);
    chk("idle_hold", wb_result, last_res);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rwe", 32'(wb_regwriteen), 0);
    chk("rst_wb_wr", 32'(wb_writereg), 0);
    chk("rst_wb_res", wb_result, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall), 0);
    reset = 1'b1;
    last_res = 32'd0;
    tick();

    // ALU op, slow load, fast store, branches, jal, load+store combo
    run_op(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 32'h8, 32'h4, 0, 0);
    idle_cycle();
    run_op(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h100, 0, 0, 0, 32'hCAFEBABE, 3);
    idle_cycle();
    run_op(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h200, 32'hDEAD, 0, 0, 32'h5555, 0);
    run_op(0, 0, 0, 1, 1, 0, 0, 0, 5'd0, 32'h9, 0, 32'h14, 32'h40, 0, 0);
    run_op(0, 0, 0, 1, 0, 0, 0, 0, 5'd0, 32'h9, 0, 32'h14, 32'h40, 0, 0);
    run_op(0, 0, 1, 0, 0, 1, 0, 1, 5'd31, 32'h77, 0, 32'h24, 32'h80, 0, 0);
    run_op(1, 1, 0, 0, 0, 0, 0, 1, 5'd3, 32'h300, 32'hBEEF, 0, 0, 32'h1111, 1);
    idle_cycle();

    // Reset during WAIT with ready in the same cycle: no retirement
    mem_valid = 1'b1; mem_memtoreg = 1'b1; mem_regwriteen = 1'b1; mem_aluout = 32'h400;
    tick();
    chk("rstw_req", 32'(dmem_req), 1);
    reset = 1'b0; dmem_ready = 1'b1;
    tick();
    chk("rstw_req_off", 32'(dmem_req), 0);
    chk("rstw_wb_valid", 32'(wb_valid), 0);
    clear_inputs();
    mem_valid = 1'b1; mem_jump = 1'b1;
    #1;
    chk("rstw_idle", 32'(redirect), 1);
    reset = 1'b1;
    clear_inputs();
    last_res = 32'd0;
    tick();

    for (int n = 0; n < 40; n++) begin
      bit ld, st, lnk;
      ld = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 2) == 0);
      lnk = !(ld || st) && ($urandom_range(0, 3) == 0);
      run_op(ld, st, lnk, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      idle_cycle();
      mem_valid = 1'b1; mem_memtoreg = 1'b1; mem_regwriteen = 1'b1; mem_aluout = 32'h500;
      tick();
      n = 0;
      while (!wb_valid && n < 50) begin
        tick();
        n++;
      end
      chk("to_bound", 32'(wb_valid), 1);
      clear_inputs();
      chk("to_err", 32'(err), 1);
      chk("to_req", 32'(dmem_req), 0);
      chk("to_rwe", 32'(wb_regwriteen), 0);
      tick();
      chk("to_single", 32'(wb_valid), 0);
      repeat (3) tick();
      chk("to_sticky", 32'(err), 1);
      reset = 1'b0;
      tick();
      chk("to_clr", 32'(err), 0);
      reset = 1'b1;
    end
`else
    chk("err_tied", 32'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
